// File: rtl/fetch_if.sv
// Fetch sequencer bus: instruction-memory port, decode handshake and control/status lines.
interface fetch_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;
    logic              fault;

    modport master (
        input  start, imem_data, if_ready, redirect, redirect_pc,
        output imem_addr, if_valid, if_instr, if_pc, halted, fault
    );

    modport slave (
        output start, imem_data, if_ready, redirect, redirect_pc,
        input  imem_addr, if_valid, if_instr, if_pc, halted, fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, fills a one-entry fetch slot toward decode,
// and handles branch redirects, HALT detection and illegal-address faults.
module fetch_sequencer #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned PC_STEP   = 4,
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    fetch_if.master  bus
);
    localparam logic [6:0] HaltOp = 7'h7F;

    typedef enum logic [1:0] {StIdle, StRun, StHalt, StFault} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] if_pc_q;
    logic              halted_q;
    logic              fault_q;

    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a < ADDR_W'(MEM_BYTES));
    endfunction

    logic slot_free;
    assign slot_free = !valid_q || bus.if_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            pc_q     <= ADDR_W'(RESET_PC);
            valid_q  <= 1'b0;
            instr_q  <= '0;
            if_pc_q  <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) state_q <= StRun;
                end
                StRun: begin
                    if (bus.redirect) begin
                        // Redirect wins over anything the current pc would have caused.
                        valid_q <= 1'b0;
                        pc_q    <= bus.redirect_pc;
                        if (!addr_legal(bus.redirect_pc)) begin
                            fault_q <= 1'b1;
                            state_q <= StFault;
                        end
                    end else if (slot_free) begin
                        if (addr_legal(pc_q)) begin
                            instr_q <= bus.imem_data;
                            if_pc_q <= pc_q;
                            valid_q <= 1'b1;
                            pc_q    <= pc_q + ADDR_W'(PC_STEP);
                            if (bus.imem_data[6:0] == HaltOp) begin
                                halted_q <= 1'b1;
                                state_q  <= StHalt;
                            end
                        end else begin
                            valid_q <= 1'b0;
                            fault_q <= 1'b1;
                            state_q <= StFault;
                        end
                    end
                end
                StHalt, StFault: begin
                    // Terminal: only let the held slot drain.
                    if (valid_q && bus.if_ready) valid_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = valid_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.halted    = halted_q;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected beats queued by stimulus, checked by a
// handshake monitor; cycle-level checks on pc, halt and fault behaviour.
module tb_fetch_sequencer;
    localparam int unsigned ADDR_W = 32;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        halted;
    } beat_t;

    logic clk;
    logic rst_n;
    logic halt_at_56;
    int   total;
    int   bad;
    beat_t exp_q[$];

    fetch_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (0),
        .PC_STEP  (4),
        .MEM_BYTES(64)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // Memory model: every word tags its own address, optionally a HALT at 56.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic h56);
        if (h56 && a == 32'd56) return 32'h0000_007F;
        return 32'hA000_0000 | a;
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr, halt_at_56);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] pc, input logic h56);
        beat_t b;
        b.pc     = pc;
        b.instr  = mem_word(pc, h56);
        b.halted = (h56 && pc == 32'd56);
        exp_q.push_back(b);
    endtask

    // Scoreboard monitor: a beat is delivered when valid && ready just before the edge.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n && bus.if_valid && bus.if_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat_pc", 64'(bus.if_pc), 64'hFFFF_FFFF);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_pc", 64'(bus.if_pc), 64'(b.pc));
                    check("beat_instr", 64'(bus.if_instr), 64'(b.instr));
                    check("beat_halted", 64'(bus.halted), 64'(b.halted));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        total           = 0;
        bad             = 0;
        halt_at_56      = 1'b0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.if_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        tick();
        tick();
        check("rst_valid", 64'(bus.if_valid), 0);
        check("rst_halted", 64'(bus.halted), 0);
        check("rst_fault", 64'(bus.fault), 0);
        check("rst_addr", 64'(bus.imem_addr), 0);
        check("rst_if_pc", 64'(bus.if_pc), 0);
        check("rst_if_instr", 64'(bus.if_instr), 0);
        rst_n = 1'b1;
        tick();
        check("idle_no_fetch", 64'(bus.if_valid), 0);

        // Streaming from start, then a 3-cycle stall on pc 8.
        push_beat(0, 0); push_beat(4, 0); push_beat(8, 0);
        bus.start = 1'b1;
        bus.if_ready = 1'b1;
        tick();
        check("start_cycle_valid", 64'(bus.if_valid), 0);
        check("start_cycle_addr", 64'(bus.imem_addr), 0);
        tick();
        bus.start = 1'b0;
        check("first_valid", 64'(bus.if_valid), 1);
        check("first_pc", 64'(bus.if_pc), 0);
        tick();
        tick();
        check("pc8_shown", 64'(bus.if_pc), 8);
        bus.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_if_pc", 64'(bus.if_pc), 8);
            check("stall_instr", 64'(bus.if_instr), 64'(mem_word(8, 0)));
            check("stall_addr", 64'(bus.imem_addr), 12);
            check("stall_valid", 64'(bus.if_valid), 1);
        end
        push_beat(12, 0);
        bus.if_ready = 1'b1;
        tick();
        check("resume_pc12", 64'(bus.if_pc), 12);

        // Redirect to 56 while 44 sits unaccepted; 56 holds HALT.
        for (int a = 16; a <= 40; a += 4) push_beat(32'(a), 0);
        halt_at_56 = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.if_valid && bus.if_pc == 44) seen = 1;
            else tick();
        end
        check("reach_pc44", 64'(seen), 1);
        bus.if_ready    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'd56;
        tick();
        bus.redirect = 1'b0;
        check("flush_valid", 64'(bus.if_valid), 0);
        check("redir_addr", 64'(bus.imem_addr), 56);
        tick();
        check("halt_valid", 64'(bus.if_valid), 1);
        check("halt_flag", 64'(bus.halted), 1);
        check("halt_if_pc", 64'(bus.if_pc), 56);
        check("halt_pc_frozen", 64'(bus.imem_addr), 60);
        push_beat(56, 1);
        bus.if_ready = 1'b1;
        tick();
        check("halt_drained", 64'(bus.if_valid), 0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'd0;
        bus.start       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_no_valid", 64'(bus.if_valid), 0);
            check("halt_addr_hold", 64'(bus.imem_addr), 60);
        end
        bus.redirect = 1'b0;
        bus.start    = 1'b0;

        // Misaligned redirect faults.
        rst_n = 1'b0;
        #1;
        check("rst_clears_halt", 64'(bus.halted), 0);
        check("rst_pc", 64'(bus.imem_addr), 0);
        halt_at_56 = 1'b0;
        tick();
        rst_n = 1'b1;
        push_beat(0, 0);
        bus.start = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        check("t5a_pc0", 64'(bus.if_pc), 0);
        tick();
        check("t5a_pc4", 64'(bus.if_pc), 4);
        bus.if_ready    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h1E;
        tick();
        bus.redirect = 1'b0;
        bus.if_ready = 1'b1;
        check("misalign_fault", 64'(bus.fault), 1);
        check("misalign_valid", 64'(bus.if_valid), 0);
        check("misalign_addr", 64'(bus.imem_addr), 32'h1E);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fault_no_valid", 64'(bus.if_valid), 0);
            check("fault_addr_hold", 64'(bus.imem_addr), 32'h1E);
        end

        // Fall-through past the end of memory.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int a = 0; a <= 60; a += 4) push_beat(32'(a), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.fault) seen = 1;
        end
        check("oob_fault", 64'(seen), 1);
        check("oob_valid", 64'(bus.if_valid), 0);
        check("oob_addr", 64'(bus.imem_addr), 64);
        rst_n = 1'b0;
        #1;
        check("rst_mid_fault", 64'(bus.fault), 0);
        check("rst_mid_fault_pc", 64'(bus.imem_addr), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_fault", 64'(bus.if_valid), 0);

        // Async reset while the slot is full; start held during reset.
        bus.if_ready = 1'b0;
        bus.start    = 1'b1;
        tick();
        tick();
        check("t6_valid_before", 64'(bus.if_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(bus.if_valid), 0);
        check("async_halted", 64'(bus.halted), 0);
        check("async_fault", 64'(bus.fault), 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("in_reset_valid", 64'(bus.if_valid), 0);
            check("in_reset_addr", 64'(bus.imem_addr), 0);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();
        tick();
        check("post_reset_idle", 64'(bus.if_valid), 0);

        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
